// File: rtl/iterative_output_divider.sv
// Multi-cycle unsigned restoring divider: y / b and y % b through a start/done handshake.
// One quotient bit is resolved per clock while in CALC; all outputs come straight from registers.
module iterative_output_divider #(
  parameter int INPUT_WIDTH  = 14,
  parameter int OUTPUT_WIDTH = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [OUTPUT_WIDTH-1:0] y,
  input  logic [INPUT_WIDTH-1:0]  b,
  output logic                    busy,
  output logic                    done,
  output logic [OUTPUT_WIDTH-1:0] quotient,
  output logic [INPUT_WIDTH-1:0]  remainder,
  output logic                    div_by_zero
);

  localparam int CNT_W = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OUTPUT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [INPUT_WIDTH:0]    part_rem;
  logic [INPUT_WIDTH:0]    rem_next;
  logic [OUTPUT_WIDTH-1:0] dvd;
  logic [OUTPUT_WIDTH-1:0] dvd_next;
  logic [INPUT_WIDTH-1:0]  divisor;
  logic [CNT_W-1:0]        count;
  logic                    accept;
  logic                    zero_div;
  logic                    last_iter;
  logic                    load_result;
  logic [INPUT_WIDTH+1:0]  shifted;
  logic [INPUT_WIDTH+1:0]  trial;
  logic                    q_bit;

  // One restoring step: the extra top bit of shifted/trial exposes the borrow.
  always_comb begin
    shifted  = {part_rem, dvd[OUTPUT_WIDTH-1]};
    trial    = shifted - {2'b00, divisor};
    q_bit    = ~trial[INPUT_WIDTH+1];
    rem_next = q_bit ? trial[INPUT_WIDTH:0] : shifted[INPUT_WIDTH:0];
    dvd_next = {dvd[OUTPUT_WIDTH-2:0], q_bit};
  end

  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    zero_div  = (b == '0);
    last_iter = (state == CALC) && (count == LAST_ITER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = zero_div ? DONE : CALC;
          load_result = zero_div;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next  = DONE;
          load_result = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_next  = zero_div ? DONE : CALC;
          load_result = zero_div;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd         <= '0;
      divisor     <= '0;
      part_rem    <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_next == CALC);
      done <= load_result;

      if (accept) begin
        dvd      <= y;
        divisor  <= b;
        part_rem <= '0;
        count    <= '0;
      end else if (state == CALC) begin
        dvd      <= dvd_next;
        part_rem <= rem_next;
        count    <= count + CNT_W'(1);
      end

      // A zero divisor is reported without iterating: saturated quotient, zero remainder.
      if (load_result) begin
        if (state == CALC) begin
          quotient    <= dvd_next;
          remainder   <= rem_next[INPUT_WIDTH-1:0];
          div_by_zero <= 1'b0;
        end else begin
          quotient    <= '1;
          remainder   <= '0;
          div_by_zero <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iterative_output_divider.sv
// Bench for iterative_output_divider: directed cases, back-to-back, abort by reset, then random
// operands, all checked every cycle against a countdown-based behavioural model.
module tb_iterative_output_divider;

  localparam int IW = 14;
  localparam int OW = 28;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [OW-1:0] y = '0;
  logic [IW-1:0] b = '0;
  logic          busy;
  logic          done;
  logic [OW-1:0] quotient;
  logic [IW-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // Model state: result registers plus a count of cycles left in the current division.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [OW-1:0] m_q = '0;
  logic [IW-1:0] m_r = '0;
  logic          m_dbz = 1'b0;
  logic [OW-1:0] pend_q = '0;
  logic [IW-1:0] pend_r = '0;
  int            left = 0;

  iterative_output_divider #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .y(y),
    .b(b),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dbz  = 1'b0;
      left   = 0;
    end else begin
      m_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_q    = pend_q;
          m_r    = pend_r;
          m_dbz  = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        if (b == '0) begin
          m_q    = '1;
          m_r    = '0;
          m_dbz  = 1'b1;
          m_done = 1'b1;
        end else begin
          left   = OW;
          pend_q = y / OW'(b);
          pend_r = IW'(y % OW'(b));
        end
      end
      m_busy = (left > 0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("quotient", 64'(quotient), 64'(m_q));
      chk("remainder", 64'(remainder), 64'(m_r));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    end
  end

  // done_edge: edges after the accepting edge until done is registered (0 = same edge).
  task automatic do_op(input logic [OW-1:0] ty, input logic [IW-1:0] tb_b,
                       output int done_edge, output int busy_cnt);
    @(negedge clk);
    start = 1'b1;
    y     = ty;
    b     = tb_b;
    @(negedge clk);
    start     = 1'b0;
    done_edge = 0;
    busy_cnt  = 0;
    while (!done && done_edge < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      done_edge++;
    end
    if (!done) chk("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk(name, 64'(0), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int de, bc, t1, t2, dseen;
    logic [OW-1:0] ry, eq;
    logic [IW-1:0] rb, er;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_quotient", 64'(quotient), 64'(0));
    chk("rst_remainder", 64'(remainder), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    #2 reset = 1'b1;
    cmp_en = 1'b1;

    do_op(28'd56, 14'd2, de, bc);
    chk("op56_q", 64'(quotient), 64'd28);
    chk("op56_r", 64'(remainder), 64'd0);
    chk("op56_dbz", 64'(div_by_zero), 64'd0);
    chk("op56_model_q", 64'(m_q), 64'd28);
    chk("op56_latency", 64'(de), 64'(OW));
    @(negedge clk);
    chk("op56_done_one_cycle", 64'(done), 64'd0);

    do_op(28'd100, 14'd7, de, bc);
    chk("op100_q", 64'(quotient), 64'd14);
    chk("op100_r", 64'(remainder), 64'd2);
    chk("op100_busy_cycles", 64'(bc), 64'd28);

    do_op(28'hFFFFFFF, 14'h3FFF, de, bc);
    chk("max_q", 64'(quotient), 64'd16385);
    chk("max_r", 64'(remainder), 64'd0);
    do_op(28'hFFFFFFF, 14'd1, de, bc);
    chk("div1_q", 64'(quotient), 64'hFFFFFFF);
    chk("div1_r", 64'(remainder), 64'd0);

    do_op(28'd12345, 14'd0, de, bc);
    chk("dz_latency", 64'(de), 64'd0);
    chk("dz_busy_cycles", 64'(bc), 64'd0);
    chk("dz_flag", 64'(div_by_zero), 64'd1);
    chk("dz_q", 64'(quotient), 64'hFFFFFFF);
    chk("dz_r", 64'(remainder), 64'd0);
    do_op(28'd9, 14'd4, de, bc);
    chk("after_dz_flag", 64'(div_by_zero), 64'd0);
    chk("after_dz_q", 64'(quotient), 64'd2);
    chk("after_dz_r", 64'(remainder), 64'd1);

    // Start during CALC with other operands must not disturb the running division.
    @(negedge clk);
    start = 1'b1; y = 28'd1000; b = 14'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; y = 28'd7; b = 14'd2;
    @(negedge clk);
    start = 1'b0; y = 28'd0; b = 14'd0;
    wait_done("calc_start_timeout");
    chk("calc_start_q", 64'(quotient), 64'd333);
    chk("calc_start_r", 64'(remainder), 64'd1);

    // Abort by reset at iteration 10.
    @(negedge clk);
    start = 1'b1; y = 28'd1000; b = 14'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_q", 64'(quotient), 64'd0);
    chk("abort_r", 64'(remainder), 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    dseen = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk("abort_no_done", 64'(dseen), 64'd0);
    do_op(28'd1000, 14'd3, de, bc);
    chk("restart_q", 64'(quotient), 64'd333);
    chk("restart_r", 64'(remainder), 64'd1);

    // Back-to-back: start held high, operands swapped in the done cycle.
    @(negedge clk);
    start = 1'b1; y = 28'd50; b = 14'd5;
    @(negedge clk);
    wait_done("b2b_first_timeout");
    t1 = cyc;
    chk("b2b_q1", 64'(quotient), 64'd10);
    chk("b2b_r1", 64'(remainder), 64'd0);
    y = 28'd51;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_drop", 64'(done), 64'd0);
    wait_done("b2b_second_timeout");
    t2 = cyc;
    chk("b2b_gap", 64'(t2 - t1), 64'd29);
    chk("b2b_q2", 64'(quotient), 64'd10);
    chk("b2b_r2", 64'(remainder), 64'd1);

    for (int i = 0; i < 1200; i++) begin
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 14'd1;
        2:       rb = IW'($urandom_range(1, 15));
        default: rb = IW'($urandom);
      endcase
      ry = ($urandom_range(0, 3) == 0) ? OW'($urandom_range(0, 20000)) : OW'($urandom);
      if (rb == '0) begin
        eq = '1;
        er = '0;
      end else begin
        eq = ry / OW'(rb);
        er = IW'(ry % OW'(rb));
      end
      do_op(ry, rb, de, bc);
      chk("rand_q", 64'(quotient), 64'(eq));
      chk("rand_r", 64'(remainder), 64'(er));
      chk("rand_dbz", 64'(div_by_zero), 64'(rb == '0));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
